page_table_walker: RTL and testbench



---
 rtl/ptw_pkg.sv | 33 +++
 rtl/page_table_walker_if.sv | 31 +++
 rtl/sat_counter.sv | 22 ++
 rtl/page_table_walker.sv | 111 +++++++++++
 tb/tb_page_table_walker.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ptw_pkg.sv
// Shared types and PTE helpers for the two-level page table walker.
package ptw_pkg;

   typedef enum logic [2:0] {
      PTW_IDLE    = 3'd0,
      PTW_L1_REQ  = 3'd1,
      PTW_L1_WAIT = 3'd2,
      PTW_L0_REQ  = 3'd3,
      PTW_L0_WAIT = 3'd4,
      PTW_RESP    = 3'd5
   } ptw_state_e;

   typedef struct packed {
      logic [19:0] ppn;
      logic [8:0]  rsvd;
      logic        t;
      logic        w;
      logic        r;
   } pte_t;

   localparam int PTE_T_BIT = 2;
   localparam int PTE_W_BIT = 1;
   localparam int PTE_R_BIT = 0;

   function automatic logic pte_is_leaf(input logic t, input logic w, input logic r);
      return (r | w) & ~t;
   endfunction

   function automatic logic pte_is_ptr(input logic t, input logic w, input logic r);
      return t & ~r & ~w;
   endfunction

endpackage

// File: rtl/page_table_walker_if.sv
// TLB-side and memory-side handshake bundle; suffixes are from the walker's view.
// valid/ready: a transfer happens on a cycle where both are high; the sender holds
// its payload and valid stable until that cycle.
interface page_table_walker_if;
   logic        ptw_req_valid_i;
   logic        ptw_req_ready_o;
   logic [31:0] ptw_vaddr_i;
   logic        ptw_resp_valid_o;
   logic        ptw_resp_ready_i;
   logic [31:0] ptw_pte_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_addr_o;
   logic        mem_resp_valid_i;
   logic        mem_resp_ready_o;
   logic [31:0] mem_resp_data_i;

   modport master (
      input  ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
             mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      output ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o,
             mem_req_valid_o, mem_addr_o, mem_resp_ready_o
   );

   modport slave (
      output ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
             mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      input  ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o,
             mem_req_valid_o, mem_addr_o, mem_resp_ready_o
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         i_clear,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_clear)
         r_count <= '0;
      else if (i_inc && (r_count != {W{1'b1}}))
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/page_table_walker.sv
// Two-level page table walker: one outstanding memory read, one PTE result per TLB miss.
module page_table_walker
   import ptw_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   page_table_walker_if.master bus,
   input  logic [19:0]      satp_ppn_i,
   output logic [CNT_W-1:0] walk_count_o,
   output logic [CNT_W-1:0] fault_count_o,
   output logic [2:0]       dbg_state_o
);

   localparam logic [2:0] S_IDLE    = PTW_IDLE;
   localparam logic [2:0] S_L1_REQ  = PTW_L1_REQ;
   localparam logic [2:0] S_L1_WAIT = PTW_L1_WAIT;
   localparam logic [2:0] S_L0_REQ  = PTW_L0_REQ;
   localparam logic [2:0] S_L0_WAIT = PTW_L0_WAIT;
   localparam logic [2:0] S_RESP    = PTW_RESP;

   logic [2:0]  r_state;
   logic [9:0]  r_vpn1;
   logic [9:0]  r_vpn0;
   logic [31:0] r_mem_addr;
   logic [31:0] r_pte;
   logic        r_fault;

   pte_t w_pte;
   logic w_leaf;
   logic w_ptr;
   logic w_walk_inc;
   logic w_fault_inc;
   logic w_unused_offset;

   assign w_pte           = bus.mem_resp_data_i;
   assign w_leaf          = pte_is_leaf(w_pte.t, w_pte.w, w_pte.r);
   assign w_ptr           = pte_is_ptr(w_pte.t, w_pte.w, w_pte.r);
   assign w_unused_offset = ^bus.ptw_vaddr_i[11:0];

   // The root address is formed at accept, which is what latching satp amounts to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_vpn1     <= '0;
         r_vpn0     <= '0;
         r_mem_addr <= '0;
         r_pte      <= '0;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.ptw_req_valid_i) begin
               r_vpn1     <= bus.ptw_vaddr_i[31:22];
               r_vpn0     <= bus.ptw_vaddr_i[21:12];
               r_mem_addr <= {satp_ppn_i, 12'h000} + {20'h0, bus.ptw_vaddr_i[31:22], 2'b00};
               r_fault    <= 1'b0;
               r_state    <= S_L1_REQ;
            end
            S_L1_REQ: if (bus.mem_req_ready_i) r_state <= S_L1_WAIT;
            S_L1_WAIT: if (bus.mem_resp_valid_i) begin
               if (w_ptr) begin
                  r_mem_addr <= {w_pte.ppn, 12'h000} + {20'h0, r_vpn0, 2'b00};
                  r_state    <= S_L0_REQ;
               end else if (w_leaf && (w_pte.ppn[9:0] == 10'h0)) begin
                  r_pte   <= {w_pte.ppn[19:10], r_vpn0, w_pte.rsvd, w_pte.t, w_pte.w, w_pte.r};
                  r_state <= S_RESP;
               end else begin
                  r_pte   <= '0;
                  r_fault <= 1'b1;
                  r_state <= S_RESP;
               end
            end
            S_L0_REQ: if (bus.mem_req_ready_i) r_state <= S_L0_WAIT;
            S_L0_WAIT: if (bus.mem_resp_valid_i) begin
               r_pte   <= w_leaf ? w_pte : 32'h0;
               r_fault <= ~w_leaf;
               r_state <= S_RESP;
            end
            S_RESP: if (bus.ptw_resp_ready_i) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_walk_inc  = (r_state == S_RESP) & bus.ptw_resp_ready_i;
   assign w_fault_inc = w_walk_inc & r_fault;

   sat_counter #(.W(CNT_W)) u_walk_cnt (
      .clk    (clk),
      .i_clear(rst),
      .i_inc  (w_walk_inc),
      .o_count(walk_count_o)
   );

   sat_counter #(.W(CNT_W)) u_fault_cnt (
      .clk    (clk),
      .i_clear(rst),
      .i_inc  (w_fault_inc),
      .o_count(fault_count_o)
   );

   assign bus.ptw_req_ready_o  = (r_state == S_IDLE);
   assign bus.ptw_resp_valid_o = (r_state == S_RESP);
   assign bus.ptw_pte_o        = r_pte;
   assign bus.mem_req_valid_o  = (r_state == S_L1_REQ) || (r_state == S_L0_REQ);
   assign bus.mem_addr_o       = r_mem_addr;
   assign bus.mem_resp_ready_o = (r_state == S_L1_WAIT) || (r_state == S_L0_WAIT);
   assign dbg_state_o          = r_state;

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: two-level walk, megapage, faults, backpressure, reset.
module tb_page_table_walker;

   logic        clk;
   logic        rst;
   logic [19:0] satp_ppn;
   logic [15:0] walk_count;
   logic [15:0] fault_count;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_reads = 0;
   int t_acc = 0;
   int exp_walks = 0;
   int exp_faults = 0;
   int reads_before;

   page_table_walker_if bus();

   page_table_walker #(.CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .satp_ppn_i   (satp_ppn),
      .walk_count_o (walk_count),
      .fault_count_o(fault_count),
      .dbg_state_o  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) n_reads <= n_reads + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"},  32'(bus.ptw_req_ready_o), 32'd1);
      chk({tag, "_resp_valid"}, 32'(bus.ptw_resp_valid_o), 32'd0);
      chk({tag, "_pte"},        bus.ptw_pte_o, 32'h0);
      chk({tag, "_mreq_valid"}, 32'(bus.mem_req_valid_o), 32'd0);
      chk({tag, "_maddr"},      bus.mem_addr_o, 32'h0);
      chk({tag, "_mresp_rdy"},  32'(bus.mem_resp_ready_o), 32'd0);
      chk({tag, "_walks"},      32'(walk_count), 32'd0);
      chk({tag, "_faults"},     32'(fault_count), 32'd0);
      chk({tag, "_state"},      32'(dbg_state), 32'd0);
   endtask

   task automatic issue(input logic [31:0] va, input logic [19:0] satp);
      int n = 0;
      bus.ptw_req_valid_i = 1'b1;
      bus.ptw_vaddr_i     = va;
      satp_ppn            = satp;
      while (!bus.ptw_req_ready_o && n < 20) begin tick(); n++; end
      chk("req_ready_at_issue", 32'(bus.ptw_req_ready_o), 32'd1);
      tick();
      bus.ptw_req_valid_i = 1'b0;
      satp_ppn            = 20'h0;
      t_acc = cyc - 1;
   endtask

   task automatic mem_serve(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] data, input int stall);
      int n = 0;
      while (!bus.mem_req_valid_o && n < 20) begin tick(); n++; end
      chk({tag, "_mreq_valid"}, 32'(bus.mem_req_valid_o), 32'd1);
      for (int i = 0; i < stall; i++) begin
         chk({tag, "_stall_addr"},  bus.mem_addr_o, exp_addr);
         chk({tag, "_stall_valid"}, 32'(bus.mem_req_valid_o), 32'd1);
         chk({tag, "_stall_busy"},  32'(bus.ptw_req_ready_o), 32'd0);
         tick();
      end
      bus.mem_req_ready_i = 1'b1;
      chk({tag, "_addr"}, bus.mem_addr_o, exp_addr);
      tick();
      bus.mem_req_ready_i  = 1'b0;
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = data;
      chk({tag, "_mresp_rdy"}, 32'(bus.mem_resp_ready_o), 32'd1);
      tick();
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_data_i  = 32'h0;
   endtask

   task automatic take_resp(input string tag, input logic [31:0] exp_pte,
                            input int stall, input int exp_lat, input bit is_fault);
      int n = 0;
      while (!bus.ptw_resp_valid_o && n < 30) begin tick(); n++; end
      chk({tag, "_resp_valid"}, 32'(bus.ptw_resp_valid_o), 32'd1);
      chk({tag, "_latency"}, 32'(cyc - t_acc), 32'(exp_lat));
      chk({tag, "_pte"}, bus.ptw_pte_o, exp_pte);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk({tag, "_hold_pte"},   bus.ptw_pte_o, exp_pte);
         chk({tag, "_hold_valid"}, 32'(bus.ptw_resp_valid_o), 32'd1);
         chk({tag, "_hold_busy"},  32'(bus.ptw_req_ready_o), 32'd0);
         chk({tag, "_hold_walks"}, 32'(walk_count), 32'(exp_walks));
      end
      bus.ptw_resp_ready_i = 1'b1;
      tick();
      bus.ptw_resp_ready_i = 1'b0;
      exp_walks++;
      if (is_fault) exp_faults++;
      chk({tag, "_idle"},   32'(bus.ptw_req_ready_o), 32'd1);
      chk({tag, "_walks"},  32'(walk_count), 32'(exp_walks));
      chk({tag, "_faults"}, 32'(fault_count), 32'(exp_faults));
   endtask

   initial begin
      rst                  = 1'b1;
      satp_ppn             = 20'h0;
      bus.ptw_req_valid_i  = 1'b0;
      bus.ptw_vaddr_i      = 32'h0;
      bus.ptw_resp_ready_i = 1'b0;
      bus.mem_req_ready_i  = 1'b0;
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_data_i  = 32'h0;
      tick(); tick();
      chk_reset_vals("rst");

      // a request alongside reset must be ignored
      bus.ptw_req_valid_i = 1'b1;
      bus.ptw_vaddr_i     = 32'h12345678;
      satp_ppn            = 20'h00080;
      tick();
      chk("rst_req_state", 32'(dbg_state), 32'd0);
      chk("rst_req_mreq", 32'(bus.mem_req_valid_o), 32'd0);
      bus.ptw_req_valid_i = 1'b0;
      rst = 1'b0;
      tick();
      chk("post_rst_state", 32'(dbg_state), 32'd0);

      issue(32'h12345678, 20'h00080);
      mem_serve("walk2_l1", 32'h00080120, 32'h00090004, 0);
      mem_serve("walk2_l0", 32'h00090D14, 32'hABCDE003, 0);
      take_resp("walk2", 32'hABCDE003, 0, 5, 1'b0);

      reads_before = n_reads;
      issue(32'h12345678, 20'h00080);
      mem_serve("mega_l1", 32'h00080120, 32'hABC00003, 0);
      take_resp("mega", 32'hABF45003, 0, 3, 1'b0);
      tick();
      chk("mega_reads", 32'(n_reads - reads_before), 32'd1);

      issue(32'h12345678, 20'h00080);
      mem_serve("zero_l1", 32'h00080120, 32'h00000000, 0);
      take_resp("zero", 32'h0, 0, 3, 1'b1);

      issue(32'h12345678, 20'h00080);
      mem_serve("misal_l1", 32'h00080120, 32'hABC01003, 0);
      take_resp("misal", 32'h0, 0, 3, 1'b1);

      issue(32'h12345678, 20'h00080);
      mem_serve("l0ptr_l1", 32'h00080120, 32'h00090004, 0);
      mem_serve("l0ptr_l0", 32'h00090D14, 32'h00090004, 0);
      take_resp("l0ptr", 32'h0, 0, 5, 1'b1);

      issue(32'h12345678, 20'h00080);
      mem_serve("bp_l1", 32'h00080120, 32'h00090004, 3);
      mem_serve("bp_l0", 32'h00090D14, 32'hABCDE003, 0);
      take_resp("bp", 32'hABCDE003, 4, 8, 1'b0);

      // reset while the L0 read is outstanding
      issue(32'h12345678, 20'h00080);
      mem_serve("mid_l1", 32'h00080120, 32'h00090004, 0);
      chk("mid_l0_addr", bus.mem_addr_o, 32'h00090D14);
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      chk("mid_in_l0_wait", 32'(dbg_state), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_vals("midrst");
      exp_walks  = 0;
      exp_faults = 0;

      issue(32'h12345678, 20'h00080);
      mem_serve("after_l1", 32'h00080120, 32'h00090004, 0);
      mem_serve("after_l0", 32'h00090D14, 32'hABCDE003, 0);
      take_resp("after", 32'hABCDE003, 0, 5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
